// File: rtl/nco_pkg.sv
// Shared NCO definitions: default frequency width and the hop sequencer state type.
package nco_pkg;

    localparam int unsigned NCO_FREQ_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN
    } hop_state_t;

endpackage

// File: rtl/nco_hop_table.sv
// Hop table register file: DEPTH x (freq, dwell), one gated synchronous write
// port, one combinational read port, cleared by synchronous reset.
module nco_hop_table #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned FREQ_W  = 16,
    parameter int unsigned DWELL_W = 16,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               busy,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [FREQ_W-1:0]  wfreq,
    input  logic [DWELL_W-1:0] wdwell,
    input  logic [AW-1:0]      rd_idx,
    output logic [FREQ_W-1:0]  rd_freq,
    output logic [DWELL_W-1:0] rd_dwell
);

    logic [FREQ_W-1:0]  freq_mem  [DEPTH];
    logic [DWELL_W-1:0] dwell_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                freq_mem[i]  <= '0;
                dwell_mem[i] <= '0;
            end
        end else if (we && !busy) begin
            freq_mem[waddr]  <= wfreq;
            dwell_mem[waddr] <= wdwell;
        end
    end

    assign rd_freq  = freq_mem[rd_idx];
    assign rd_dwell = dwell_mem[rd_idx];

endmodule

// File: rtl/nco_hop_sequencer.sv
// Frequency-hopping scheduler driving the NCO load/enable/reset controls.
// Define NCO_HOP_LOOP_EN to wrap from the last entry back to entry 0 forever.
module nco_hop_sequencer
    import nco_pkg::*;
#(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned FREQ_W        = NCO_FREQ_W,
    parameter int unsigned DWELL_W       = 16,
    parameter int unsigned SETTLE_CYCLES = 2,
    localparam int unsigned AW           = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [FREQ_W-1:0]  cfg_freq,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [AW:0]        num_entries,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      cur_idx,
    output logic               hop_strobe,
    output logic               nco_ld_freq,
    output logic [FREQ_W-1:0]  nco_freq,
    output logic               nco_out_en,
    output logic               nco_resetn
);

    localparam int unsigned SW    = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [AW:0] MAX_N = (AW+1)'(DEPTH);

    hop_state_t         state, state_nxt;
    logic [AW-1:0]      idx_nxt;
    logic [AW:0]        num_lat, num_nxt;
    logic [SW-1:0]      settle_cnt, settle_nxt;
    logic [DWELL_W-1:0] dwell_cnt, dwell_nxt;
    logic               done_nxt;
    logic               last_entry;
    logic               wr_bypass;
    logic [FREQ_W-1:0]  tbl_freq, ld_freq_val;
    logic [DWELL_W-1:0] tbl_dwell, ld_dwell_val;

    nco_hop_table #(
        .DEPTH   (DEPTH),
        .FREQ_W  (FREQ_W),
        .DWELL_W (DWELL_W)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .we       (cfg_we),
        .waddr    (cfg_addr),
        .wfreq    (cfg_freq),
        .wdwell   (cfg_dwell),
        .rd_idx   (idx_nxt),
        .rd_freq  (tbl_freq),
        .rd_dwell (tbl_dwell)
    );

    // The entry is captured on the edge that enters LOAD, so a write landing on
    // that same edge must be forwarded past the table.
    assign wr_bypass    = cfg_we && !busy && (cfg_addr == idx_nxt);
    assign ld_freq_val  = wr_bypass ? cfg_freq  : tbl_freq;
    assign ld_dwell_val = wr_bypass ? cfg_dwell : tbl_dwell;
    assign last_entry   = ({1'b0, cur_idx} + 1'b1) >= num_lat;

    always_comb begin
        state_nxt  = state;
        idx_nxt    = cur_idx;
        num_nxt    = num_lat;
        settle_nxt = settle_cnt;
        dwell_nxt  = dwell_cnt;
        done_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop && (num_entries != '0) && (num_entries <= MAX_N)) begin
                    state_nxt = ST_LOAD;
                    idx_nxt   = '0;
                    num_nxt   = num_entries;
                end
            end
            ST_LOAD: begin
                state_nxt  = ST_SETTLE;
                settle_nxt = SW'(SETTLE_CYCLES - 1);
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) state_nxt = ST_RUN;
                else                  settle_nxt = settle_cnt - 1'b1;
            end
            ST_RUN: begin
                if (dwell_cnt <= DWELL_W'(1)) begin
                    if (!last_entry) begin
                        idx_nxt   = cur_idx + 1'b1;
                        state_nxt = ST_LOAD;
                    end else begin
`ifdef NCO_HOP_LOOP_EN
                        idx_nxt   = '0;
                        state_nxt = ST_LOAD;
`else
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
`endif
                    end
                end else begin
                    dwell_nxt = dwell_cnt - 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (stop && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cur_idx     <= '0;
            num_lat     <= '0;
            settle_cnt  <= '0;
            dwell_cnt   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hop_strobe  <= 1'b0;
            nco_ld_freq <= 1'b0;
            nco_out_en  <= 1'b0;
            nco_resetn  <= 1'b0;
            nco_freq    <= '0;
        end else begin
            state       <= state_nxt;
            cur_idx     <= idx_nxt;
            num_lat     <= num_nxt;
            settle_cnt  <= settle_nxt;
            busy        <= (state_nxt != ST_IDLE);
            done        <= done_nxt;
            hop_strobe  <= (state_nxt == ST_LOAD);
            nco_ld_freq <= (state_nxt == ST_LOAD);
            nco_out_en  <= (state_nxt == ST_RUN);
            nco_resetn  <= (state_nxt != ST_LOAD);
            if (state_nxt == ST_LOAD) begin
                nco_freq  <= ld_freq_val;
                dwell_cnt <= (ld_dwell_val == '0) ? DWELL_W'(1) : ld_dwell_val;
            end else begin
                dwell_cnt <= dwell_nxt;
            end
        end
    end

endmodule
